acf_axis_packer: RTL and testbench

- Downstream stage of the single-channel ACF block.
- Consumes the ACF element stream (photon count followed by correlator bins, one element per write strobe).
- Buffers the elements in a FIFO and frames them onto a 32-bit AXI4-Stream master for the DMA/PC link.
- Each frame is one header beat, then two beats per element (low word, high word), with TLAST on the final beat.

---
 rtl/acf_pkg.sv | 24 ++
 rtl/acf_sync_fifo.sv | 66 ++++++
 rtl/acf_axis_packer.sv | 180 ++++++++++++++++++
 tb/tb_acf_axis_packer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acf_pkg.sv
// Shared definitions for the ACF stream packer: element geometry helpers,
// framing FSM states and the default header tag.
package acf_pkg;

    localparam logic [15:0] HDR_TAG_DEFAULT = 16'hACF0;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LO,
        HI
    } state_e;

    // Photon count plus the per-block correlator fields.
    function automatic int elem_w(input int num_bins);
        return num_bins + 33;
    endfunction

    // Photon count element followed by BIN_SIZE bins for each of NUM_BINS+1 blocks.
    function automatic int elems(input int bin_size, input int num_bins);
        return bin_size * (num_bins + 1) + 1;
    endfunction

endpackage

// File: rtl/acf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: the head entry is visible whenever
// empty_o is low, and rd_next_o exposes the entry queued behind it.
module acf_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int PEEK_W = WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [PEEK_W-1:0]      rd_next_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_nx;
    logic [AW:0]      count_q;
    logic             push;
    logic             pop;

    // Fullness is judged on the pre-pop count, so a same-cycle pop never makes room.
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_ptr_nx = rd_ptr_q + AW'(1);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_next_o = mem_q[rd_ptr_nx][PEEK_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nx;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/acf_axis_packer.sv
// Frames the ACF element stream onto a 32-bit AXI4-Stream master: one header beat,
// then a low/high word pair per element, with TLAST on the frame's final high word.
module acf_axis_packer
    import acf_pkg::*;
#(
    parameter int          BIN_SIZE   = 8,
    parameter int          NUM_BINS   = 20,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [15:0] HDR_TAG    = HDR_TAG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BINS+32:0] acfEl,
    input  logic                 wrEn,
    input  logic                 clrOvf,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic [15:0]          dropCnt,
    output logic [15:0]          frameSeq
);
    localparam int               ELEM_W   = elem_w(NUM_BINS);
    localparam int               ELEMS    = elems(BIN_SIZE, NUM_BINS);
    localparam int               CNT_W    = $clog2(ELEMS + 1);
    localparam int               FCW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEMS - 1);

    logic [ELEM_W-1:0] head;
    logic [31:0]       next_lo;
    logic [31:0]       head_lo;
    logic [31:0]       head_hi;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_count;
    logic              pop;
    logic              hs;
    logic              drop;

    state_e            state_q, state_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       frame_seq_q, frame_seq_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    acf_sync_fifo #(
        .WIDTH  (ELEM_W),
        .DEPTH  (FIFO_DEPTH),
        .PEEK_W (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wrEn),
        .wr_data_i (acfEl),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .rd_next_o (next_lo),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign head_lo = head[31:0];
    assign head_hi = 32'(head[ELEM_W-1:32]);
    assign hs      = tvalid_q && m_axis_tready;
    assign drop    = wrEn && fifo_full;

    // Every beat is preloaded into tdata_q one edge ahead; the element is popped only
    // after its high word is accepted, so the next low word comes from the peek port.
    always_comb begin
        state_d     = state_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        cnt_d       = cnt_q;
        frame_seq_d = frame_seq_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && cnt_q == '0) begin
                    state_d  = HDR;
                    tvalid_d = 1'b1;
                    tdata_d  = {HDR_TAG, frame_seq_q};
                    tlast_d  = 1'b0;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d  = LO;
                    tvalid_d = !fifo_empty;
                    tdata_d  = head_lo;
                end
            end
            LO: begin
                if (!tvalid_q) begin
                    if (!fifo_empty) begin
                        tvalid_d = 1'b1;
                        tdata_d  = head_lo;
                    end
                end else if (hs) begin
                    state_d = HI;
                    tdata_d = head_hi;
                    tlast_d = (cnt_q == LAST_IDX);
                end
            end
            HI: begin
                if (hs) begin
                    pop     = 1'b1;
                    tlast_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d       = '0;
                        frame_seq_d = frame_seq_q + 16'd1;
                        state_d     = IDLE;
                        tvalid_d    = 1'b0;
                    end else begin
                        cnt_d    = cnt_q + CNT_W'(1);
                        state_d  = LO;
                        tvalid_d = (fifo_count > FCW'(1));
                        tdata_d  = next_lo;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clrOvf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clrOvf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            cnt_q       <= '0;
            frame_seq_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            cnt_q       <= cnt_d;
            frame_seq_q <= frame_seq_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign overflow      = overflow_q;
    assign dropCnt       = drop_cnt_q;
    assign frameSeq      = frame_seq_q;

endmodule

// File: tb/tb_acf_axis_packer.sv
// Self-checking bench for acf_axis_packer: a beat scoreboard fed by a frame-level
// model of the stream, plus directed latency, overflow and reset sequences.
module tb_acf_axis_packer;

    localparam int          ELEMS   = 8 * (20 + 1) + 1;
    localparam int          BEATS   = 2 * ELEMS + 1;
    localparam logic [15:0] HDR_TAG = 16'hACF0;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [52:0] el;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [52:0] acfEl = '0;
    logic        wrEn = 1'b0;
    logic        clrOvf = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        overflow;
    logic [15:0] dropCnt;
    logic [15:0] frameSeq;

    int          checks = 0;
    int          errors = 0;
    int          beats_seen = 0;
    int          ready_mode = 0;
    beat_t       exp_q[$];
    int          model_idx = 0;
    logic [15:0] model_seq = '0;
    vec_t        vecs[4];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    acf_axis_packer dut (
        .clk           (clk),
        .rst           (rst),
        .acfEl         (acfEl),
        .wrEn          (wrEn),
        .clrOvf        (clrOvf),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .dropCnt       (dropCnt),
        .frameSeq      (frameSeq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Frame-level model: element n of the stream sits at position n mod ELEMS of a frame.
    task automatic model_accept(input logic [31:0] lo, input logic [31:0] hi);
        int pos;
        pos = model_idx % ELEMS;
        if (pos == 0) begin
            exp_q.push_back('{data: {HDR_TAG, model_seq}, last: 1'b0});
        end
        exp_q.push_back('{data: lo, last: 1'b0});
        exp_q.push_back('{data: hi, last: (pos == ELEMS - 1)});
        model_idx++;
        if (pos == ELEMS - 1) begin
            model_seq = model_seq + 16'd1;
        end
    endtask

    task automatic write_elem(input logic [52:0] el, input logic acc,
                              input logic [31:0] lo, input logic [31:0] hi);
        @(posedge clk);
        #1;
        acfEl = el;
        wrEn  = 1'b1;
        if (acc) begin
            model_accept(lo, hi);
        end
        @(posedge clk);
        #1;
        wrEn = 1'b0;
    endtask

    task automatic write_rand(input logic acc);
        logic [52:0] el;
        el = 53'({$urandom(), $urandom()});
        write_elem(el, acc, el[31:0], 32'(el >> 32));
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats outstanding, required 0", nm, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        rst    = 1'b1;
        wrEn   = 1'b0;
        clrOvf = 1'b0;
        exp_q.delete();
        model_idx = 0;
        model_seq = '0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({nm, "_tlast"}, 64'(m_axis_tlast), 64'(0));
        chk({nm, "_tdata"}, 64'(m_axis_tdata), 64'(0));
        chk({nm, "_ovf"}, 64'({overflow, dropCnt}), 64'(0));
        chk({nm, "_seq"}, 64'(frameSeq), 64'(0));
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every accepted beat must match the model; a stalled beat must hold.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got data=%h last=%0b, required no beat",
                             m_axis_tdata, m_axis_tlast);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    if (m_axis_tdata !== b.data || m_axis_tlast !== b.last) begin
                        errors++;
                        $display("FAIL beat_%0d: got data=%h last=%0b, required data=%h last=%0b",
                                 beats_seen, m_axis_tdata, m_axis_tlast, b.data, b.last);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{el: 53'h1F_0000_0000_0003, lo: 32'h0000_0003, hi: 32'h001F_0000};
        vecs[1] = '{el: 53'h0,                 lo: 32'h0000_0000, hi: 32'h0000_0000};
        vecs[2] = '{el: {53{1'b1}},            lo: 32'hFFFF_FFFF, hi: 32'h001F_FFFF};
        vecs[3] = '{el: 53'h10_0000_8000_0001, lo: 32'h8000_0001, hi: 32'h0010_0000};

        // Reset, then a quiet idle stretch.
        do_reset("reset");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", 64'({m_axis_tvalid, overflow, frameSeq}), 64'(0));
        end
        $display("phase reset/idle done");

        // Full burst of k+1 values with ready held high; header latency checked directly.
        ready_mode = 1;
        beats_seen = 0;
        @(posedge clk);
        #1;
        acfEl = 53'd1;
        wrEn  = 1'b1;
        model_accept(32'd1, 32'd0);
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        @(negedge clk);
        chk("latency_early", 64'(m_axis_tvalid), 64'(0));
        @(negedge clk);
        chk("latency_hdr", 64'({m_axis_tvalid, m_axis_tdata}), {31'd0, 1'b1, 32'hACF0_0000});
        for (int k = 1; k < ELEMS; k++) begin
            write_elem(53'(k + 1), 1'b1, 32'(k + 1), 32'd0);
        end
        wait_drain(2000, "burst");
        chk("burst_beats", 64'(beats_seen), 64'(BEATS));
        chk("burst_seq", 64'(frameSeq), 64'(1));
        chk("burst_idle", 64'(m_axis_tvalid), 64'(0));
        $display("frame seq=0 burst done beats=%0d", beats_seen);

        // Table rows open the first frame; random elements and a random ready fill the rest.
        for (int f = 0; f < 3; f++) begin
            ready_mode = 2;
            beats_seen = 0;
            for (int e = 0; e < ELEMS; e++) begin
                if (f == 0 && e < 4) begin
                    write_elem(vecs[e].el, 1'b1, vecs[e].lo, vecs[e].hi);
                end else begin
                    write_rand(1'b1);
                end
            end
            wait_drain(4000, "rand_frame");
            chk("rand_frame_beats", 64'(beats_seen), 64'(BEATS));
            $display("frame random-ready done beats=%0d seq=%0d", beats_seen, frameSeq);
        end
        chk("rand_seq", 64'(frameSeq), 64'(4));

        // Overflow: ready low, 300 writes into a 256-deep FIFO.
        ready_mode = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            write_rand(i < 256);
            if (i == 255) begin
                chk("ovf_boundary", 64'({overflow, dropCnt}), 64'(0));
            end
        end
        chk("ovf_flag", 64'(overflow), 64'(1));
        chk("ovf_count", 64'(dropCnt), 64'(44));
        @(posedge clk);
        #1;
        clrOvf = 1'b1;
        @(posedge clk);
        #1;
        clrOvf = 1'b0;
        chk("ovf_clear", 64'({overflow, dropCnt}), 64'(0));
        @(posedge clk);
        #1;
        clrOvf = 1'b1;
        wrEn   = 1'b1;
        acfEl  = 53'h155;
        @(posedge clk);
        #1;
        clrOvf = 1'b0;
        wrEn   = 1'b0;
        chk("ovf_clr_drop", 64'({overflow, dropCnt}), {47'd0, 1'b1, 16'd1});
        $display("overflow phase done");
        ready_mode = 1;
        wait_drain(3000, "ovf_drain");
        chk("ovf_drain_seq", 64'(frameSeq), 64'(5));

        // Reset in the middle of a frame, then a clean burst.
        do_reset("reset_clean");
        beats_seen = 0;
        for (int i = 0; i < 200 && beats_seen < 100; i++) begin
            write_rand(1'b1);
        end
        chk("mid_reached", 64'(beats_seen >= 100), 64'(1));
        do_reset("reset_mid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({m_axis_tvalid, m_axis_tlast}), 64'(0));
        end
        beats_seen = 0;
        for (int e = 0; e < ELEMS; e++) begin
            write_rand(1'b1);
        end
        wait_drain(2000, "post_rst");
        chk("post_rst_beats", 64'(beats_seen), 64'(BEATS));
        chk("post_rst_seq", 64'(frameSeq), 64'(1));
        $display("post-reset burst done beats=%0d", beats_seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
